// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Single-outstanding request front end for an asynchronous 16-bit SRAM.
//   One access is handled at a time. A read keeps CE_N/OE_N low for
//   READ_WAIT cycles and then captures the bus. A write runs three cycles:
//   setup, WE_N pulse, hold. A request with no byte enables runs one idle
//   cycle and then completes without touching the SRAM.
//
// Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both high. req_ready is high only in IDLE. rsp_valid and
//   wr_done are single-cycle pulses with no back-pressure.
//
// Ports
//   Clk, Reset          clock; synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = write, 0 = read
//   req_addr[19:0]      word address
//   req_wdata[15:0]     write data
//   req_be[1:0]         byte enables (bit1 upper, bit0 lower)
//   rsp_valid           read data valid pulse
//   rsp_rdata[15:0]     read data, held until the next read completes
//   wr_done             write complete pulse
//   SRAM_*              SRAM address, data bus and active-low strobes
//   dbg_state_o[2:0]    current FSM state, for debug and checkers
//
// READ_WAIT must be in the range 1..4.
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int READ_WAIT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        wr_done,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        NOP_DONE = 3'd5
    } state_t;

    state_t      state_q;
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic        we_q;
    logic [1:0]  wait_cnt_q;
    logic [15:0] rdata_q;
    logic        rsp_valid_q;
    logic        wr_done_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        ub_n_q;
    logic        lb_n_q;
    logic        dq_oe_q;

    // Captured read word with disabled byte lanes forced to zero.
    logic [15:0] rd_masked_d;
    assign rd_masked_d = {be_q[1] ? SRAM_DQ[15:8] : 8'h00,
                          be_q[0] ? SRAM_DQ[7:0]  : 8'h00};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= 20'd0;
            wdata_q     <= 16'd0;
            be_q        <= 2'b00;
            we_q        <= 1'b0;
            wait_cnt_q  <= 2'd0;
            rdata_q     <= 16'd0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        we_q    <= req_we;
                        if (req_be == 2'b00) begin
                            // Nothing to transfer: complete without strobes.
                            state_q <= NOP_DONE;
                        end else if (req_we) begin
                            state_q <= WR_SETUP;
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= 1'b1;
                            we_n_q  <= 1'b1;
                            ub_n_q  <= ~req_be[1];
                            lb_n_q  <= ~req_be[0];
                            dq_oe_q <= 1'b1;
                        end else begin
                            state_q    <= RD_WAIT;
                            wait_cnt_q <= 2'(READ_WAIT - 1);
                            ce_n_q     <= 1'b0;
                            oe_n_q     <= 1'b0;
                            we_n_q     <= 1'b1;
                            ub_n_q     <= ~req_be[1];
                            lb_n_q     <= ~req_be[0];
                        end
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        rdata_q     <= rd_masked_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        ub_n_q      <= 1'b1;
                        lb_n_q      <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                WR_SETUP: begin
                    we_n_q  <= 1'b0;
                    state_q <= WR_PULSE;
                end
                WR_PULSE: begin
                    we_n_q  <= 1'b1;
                    state_q <= WR_HOLD;
                end
                WR_HOLD: begin
                    // Data and strobes are released together at the end of hold.
                    ce_n_q    <= 1'b1;
                    ub_n_q    <= 1'b1;
                    lb_n_q    <= 1'b1;
                    dq_oe_q   <= 1'b0;
                    wr_done_q <= 1'b1;
                    state_q   <= IDLE;
                end
                NOP_DONE: begin
                    if (we_q) begin
                        wr_done_q <= 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= 16'd0;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    ub_n_q  <= 1'b1;
                    lb_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign wr_done     = wr_done_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_UB_N   = ub_n_q;
    assign SRAM_LB_N   = lb_n_q;
    assign SRAM_DQ     = dq_oe_q ? wdata_q : 16'hzzzz;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//   Bench for sram_controller with READ_WAIT = 1. Contains a behavioural
//   asynchronous SRAM on the DQ bus, a transaction-level reference memory,
//   an expected-read queue, and a per-cycle monitor that derives the
//   expected strobe pattern from the access type and its age in cycles.
// ---------------------------------------------------------------------------
module tb_sram_controller;
    localparam int READ_WAIT = 1;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [19:0] req_addr = 20'd0;
    logic [15:0] req_wdata = 16'd0;
    logic [1:0]  req_be = 2'b00;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        wr_done;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] sram_dq;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [2:0]  dbg_state;

    initial forever #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    sram_controller #(.READ_WAIT(READ_WAIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(sram_dq),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .dbg_state_o(dbg_state)
    );

    logic [4:0] strobes;
    assign strobes = {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N};

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- behavioural SRAM ----------------
    function automatic logic [15:0] init_word(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'hA5C};
    endfunction

    logic [15:0] dev_mem [0:1048575];
    logic        dev_drive;
    assign dev_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign sram_dq   = dev_drive ? dev_mem[SRAM_ADDR] : 16'hzzzz;

    // Data is latched while WE_N is low and committed when WE_N rises with
    // CE_N still low; a reset that drops CE_N abandons the write.
    logic        dw_arm = 1'b0;
    logic [19:0] dw_addr;
    logic [15:0] dw_data;
    logic [1:0]  dw_be;
    initial forever begin
        @(negedge Clk);
        if (dw_arm) begin
            if (!SRAM_CE_N && SRAM_WE_N) begin
                if (dw_be[1]) dev_mem[dw_addr][15:8] = dw_data[15:8];
                if (dw_be[0]) dev_mem[dw_addr][7:0]  = dw_data[7:0];
            end
            if (SRAM_WE_N) dw_arm = 1'b0;
        end
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            dw_arm  = 1'b1;
            dw_addr = SRAM_ADDR;
            dw_data = sram_dq;
            dw_be   = {~SRAM_UB_N, ~SRAM_LB_N};
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [logic [19:0]];
    logic [15:0] exp_q [$];

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [15:0] mask_be(input logic [15:0] d, input logic [1:0] be);
        return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
    endfunction

    task automatic ref_wr(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] m;
        m = ref_rd(a);
        if (be[1]) m[15:8] = d[15:8];
        if (be[0]) m[7:0]  = d[7:0];
        ref_mem[a] = m;
    endtask

    // ---------------- monitor / scoreboard ----------------
    // pend_acc is the cycle before the accept edge, so age k = 1 is the
    // first cycle of the access and the completion pulse shows at k = lat+1.
    bit          armed = 0;
    bit          pend_valid = 0;
    logic        pend_we;
    logic [19:0] pend_addr;
    logic [15:0] pend_wdata;
    logic [1:0]  pend_be;
    int          pend_acc, pend_lat, k;
    logic [19:0] exp_addr = 20'd0;
    bit          addr_known = 1;
    logic [15:0] exp_rdata = 16'd0;
    logic [15:0] last_rsp = 16'd0;
    int          rsp_cyc = 0, done_cyc = 0;
    int          oe_low_cnt = 0, we_low_cnt = 0, ce_low_cnt = 0;
    logic [4:0]  exp_s;
    logic        exp_rv, exp_wd;

    initial forever begin
        @(negedge Clk);
        if (armed) begin
            k      = pend_valid ? cyc - pend_acc : 0;
            exp_s  = 5'b11111;
            exp_rv = 1'b0;
            exp_wd = 1'b0;
            if (pend_valid && pend_be != 2'b00) begin
                if (!pend_we && k >= 1 && k <= READ_WAIT) exp_s = {3'b001, ~pend_be};
                if (pend_we && k >= 1 && k <= 3) exp_s = {2'b01, (k == 2) ? 1'b0 : 1'b1, ~pend_be};
                if (pend_we && k >= 1 && k <= 3) check_eq("dq_wdata", 32'(sram_dq), 32'(pend_wdata));
            end
            if (pend_valid && k >= 1 && k <= pend_lat) check_eq("sram_addr", 32'(SRAM_ADDR), 32'(pend_addr));
            else if (addr_known) check_eq("sram_addr_rst", 32'(SRAM_ADDR), 32'(exp_addr));
            if (pend_valid && k == pend_lat + 1) begin
                exp_rv = !pend_we;
                exp_wd = pend_we;
            end
            if (!SRAM_OE_N) oe_low_cnt++;
            if (!SRAM_WE_N) we_low_cnt++;
            if (!SRAM_CE_N) ce_low_cnt++;
            check_eq("strobes", 32'(strobes), 32'(exp_s));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check_eq("wr_done", 32'(wr_done), 32'(exp_wd));
            if (exp_rv) begin
                if (exp_q.size() == 0) check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
                else exp_rdata = exp_q.pop_front();
                last_rsp = rsp_rdata;
                rsp_cyc  = cyc;
            end
            if (exp_wd) begin
                ref_wr(pend_addr, pend_wdata, pend_be);
                done_cyc = cyc;
            end
            check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            if (exp_rv || exp_wd) pend_valid = 0;
            check_eq("req_ready", 32'(req_ready), 32'(!pend_valid));
            if (Reset) begin
                pend_valid = 0;
                exp_q.delete();
                exp_rdata  = 16'd0;
                exp_addr   = 20'd0;
                addr_known = 1;
            end else if (req_valid && req_ready) begin
                pend_valid = 1;
                pend_we    = req_we;
                pend_addr  = req_addr;
                pend_wdata = req_wdata;
                pend_be    = req_be;
                pend_acc   = cyc;
                pend_lat   = (req_be == 2'b00) ? 1 : (req_we ? 3 : READ_WAIT);
                addr_known = 0;
                if (!req_we) exp_q.push_back(mask_be(ref_rd(req_addr), req_be));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accept edge with
    // acc set to the cycle number of the first access cycle.
    task automatic send(input logic we, input logic [19:0] a, input logic [15:0] d,
                        input logic [1:0] be, input bit hold, output int acc);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        req_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (req_ready && !Reset) begin
                @(posedge Clk);
                #1;
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check_eq("accept_timeout", 32'd0, 32'd1);
        if (!hold) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 20'($urandom);
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 30; n++) begin
            if (!pend_valid) break;
            @(posedge Clk);
            #1;
        end
        if (pend_valid) check_eq("idle_timeout", 32'(pend_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int acc, acc2, oe0, we0, ce0;
    logic [19:0] pool [0:7];

    initial begin
        for (int i = 0; i < 1048576; i++) dev_mem[i] = init_word(20'(i));
        dev_mem[20'h00008] = 16'h867D;  ref_mem[20'h00008] = 16'h867D;
        dev_mem[20'h00200] = 16'hCD63;  ref_mem[20'h00200] = 16'hCD63;

        @(posedge Clk); #1;
        armed = 1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_strobes", 32'(strobes), 32'h1F);

        // Read of preloaded word.
        oe0 = oe_low_cnt;
        send(1'b0, 20'h00008, 16'h0000, 2'b11, 0, acc);
        wait_idle();
        check_eq("rd8_data", 32'(last_rsp), 32'h867D);
        check_eq("rd8_latency", 32'(rsp_cyc - acc), 32'd1);
        check_eq("rd8_oe_cycles", 32'(oe_low_cnt - oe0), 32'd1);

        // Full write then read back.
        we0 = we_low_cnt;
        send(1'b1, 20'h00100, 16'hBEEF, 2'b11, 0, acc);
        wait_idle();
        check_eq("wr100_latency", 32'(done_cyc - acc), 32'd3);
        check_eq("wr100_we_cycles", 32'(we_low_cnt - we0), 32'd1);
        send(1'b0, 20'h00100, 16'h0000, 2'b11, 0, acc);
        wait_idle();
        check_eq("rd100_data", 32'(last_rsp), 32'hBEEF);

        // Upper-byte write, then full and lower-byte reads.
        send(1'b1, 20'h00200, 16'h1234, 2'b10, 0, acc);
        wait_idle();
        send(1'b0, 20'h00200, 16'h0000, 2'b11, 0, acc);
        wait_idle();
        check_eq("rd200_full", 32'(last_rsp), 32'h1263);
        send(1'b0, 20'h00200, 16'h0000, 2'b01, 0, acc);
        wait_idle();
        check_eq("rd200_low", 32'(last_rsp), 32'h0063);

        // Reset during the WE_N pulse abandons the write.
        send(1'b1, 20'h00300, 16'hAAAA, 2'b11, 0, acc);
        @(posedge Clk); #1;
        check_eq("pulse_we_n", 32'(SRAM_WE_N), 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check_eq("abort_strobes", 32'(strobes), 32'h1F);
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        @(posedge Clk); #1;
        check_eq("abort_no_done", 32'(wr_done), 32'd0);
        send(1'b0, 20'h00300, 16'h0000, 2'b11, 0, acc);
        wait_idle();
        check_eq("abort_mem", 32'(last_rsp), 32'(init_word(20'h00300)));

        // No-byte-enable read.
        ce0 = ce_low_cnt;
        send(1'b0, 20'h00008, 16'h0000, 2'b00, 0, acc);
        wait_idle();
        check_eq("nop_rd_data", 32'(last_rsp), 32'h0000);
        check_eq("nop_rd_latency", 32'(rsp_cyc - acc), 32'd1);
        check_eq("nop_ce_cycles", 32'(ce_low_cnt - ce0), 32'd0);

        // Back-to-back write then read with valid held.
        send(1'b1, 20'h00400, 16'h5A3C, 2'b11, 1, acc);
        send(1'b0, 20'h00400, 16'h0000, 2'b11, 0, acc2);
        wait_idle();
        check_eq("b2b_gap", 32'(acc2 - acc), 32'd4);
        check_eq("b2b_data", 32'(last_rsp), 32'h5A3C);

        // Randomized traffic over a small address pool.
        pool[0] = 20'hFFFFF; pool[1] = 20'h00000; pool[2] = 20'h00008; pool[3] = 20'h00200;
        for (int i = 4; i < 8; i++) pool[i] = 20'($urandom);
        for (int i = 0; i < 400; i++) begin
            bit hold;
            hold = ($urandom_range(0, 3) == 0);
            send(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom),
                 2'($urandom_range(0, 3)), hold, acc);
            if ($urandom_range(0, 29) == 0) begin
                Reset = 1'b1;
                @(posedge Clk); #1;
                Reset = 1'b0;
            end
            if (!hold) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
            end
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (3) begin @(posedge Clk); #1; end
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("final dbg state %0d", dbg_state);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
